// File: rtl/time_cnt_mc.sv
// Multi-channel countdown timer bank: per-channel reload, one-shot or periodic
// expiry, kick/stop control, sticky expiry flags and registered count readback.
module time_cnt_mc #(
  parameter int          NUM_CH          = 4,
  parameter int          CNT_W           = 32,
  parameter logic [31:0] DEFAULT_TIMEOUT = 32'h7735_9400,
  parameter int          CH_IDX_W        = 2
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [NUM_CH-1:0]   start,
  input  logic [NUM_CH-1:0]   stop,
  input  logic [NUM_CH-1:0]   periodic,
  input  logic [NUM_CH-1:0]   clr_expired,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_value,
  input  logic [CH_IDX_W-1:0] rd_ch,
  output logic [NUM_CH-1:0]   time_out,
  output logic [NUM_CH-1:0]   expired,
  output logic [NUM_CH-1:0]   busy,
  output logic                any_expired,
  output logic [CNT_W-1:0]    rd_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXPD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_RELOAD = CNT_W'(DEFAULT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t              state_r     [NUM_CH];
  state_t              state_nxt_s [NUM_CH];
  logic [CNT_W-1:0]    cnt_r       [NUM_CH];
  logic [CNT_W-1:0]    cnt_nxt_s   [NUM_CH];
  logic [CNT_W-1:0]    reload_r    [NUM_CH];
  logic [NUM_CH-1:0]   exp_nxt_s;
  logic [NUM_CH-1:0]   tout_nxt_s;
  logic [NUM_CH-1:0]   busy_nxt_s;
  logic [NUM_CH-1:0]   time_out_r;
  logic [NUM_CH-1:0]   expired_r;
  logic [NUM_CH-1:0]   busy_r;
  logic                any_expired_r;
  logic [CNT_W-1:0]    rd_cnt_r;
  logic [CNT_W-1:0]    rd_sel_s;

  // A zero reload is promoted to one so a channel can never stall in RUN.
  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] r;
    if (x != CNT_ZERO) begin
      r = x;
    end else begin
      r = CNT_ONE;
    end
    return r;
  endfunction

  // Per-channel next state; priority is stop, then start, then countdown.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      tout_nxt_s[i]  = 1'b0;
      exp_nxt_s[i]   = expired_r[i] & ~clr_expired[i];
      if (stop[i]) begin
        state_nxt_s[i] = ST_IDLE;
        cnt_nxt_s[i]   = CNT_ZERO;
      end else if (start[i]) begin
        state_nxt_s[i] = ST_RUN;
        cnt_nxt_s[i]   = eff(reload_r[i]);
        exp_nxt_s[i]   = 1'b0;
      end else begin
        case (state_r[i])
          ST_RUN: begin
            if (cnt_r[i] == CNT_ONE) begin
              tout_nxt_s[i] = 1'b1;
              exp_nxt_s[i]  = 1'b1;
              if (periodic[i]) begin
                cnt_nxt_s[i] = eff(reload_r[i]);
              end else begin
                state_nxt_s[i] = ST_EXPD;
                cnt_nxt_s[i]   = CNT_ZERO;
              end
            end else if (cnt_r[i] != CNT_ZERO) begin
              cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
              cnt_nxt_s[i] = CNT_ZERO;
            end
          end
          ST_IDLE: begin
            cnt_nxt_s[i] = CNT_ZERO;
          end
          ST_EXPD: begin
            cnt_nxt_s[i] = CNT_ZERO;
          end
          default: begin
            state_nxt_s[i] = ST_IDLE;
            cnt_nxt_s[i]   = CNT_ZERO;
          end
        endcase
      end
      busy_nxt_s[i] = (state_nxt_s[i] == ST_RUN);
    end
  end

  // Readback mux; indices beyond the last channel read as zero.
  always_comb begin
    rd_sel_s = CNT_ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_IDX_W'(i)) begin
        rd_sel_s = cnt_r[i];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
  end

  // Channel state, reload registers and all registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]  <= ST_IDLE;
        cnt_r[i]    <= CNT_ZERO;
        reload_r[i] <= DEF_RELOAD;
      end
      time_out_r    <= {NUM_CH{1'b0}};
      expired_r     <= {NUM_CH{1'b0}};
      busy_r        <= {NUM_CH{1'b0}};
      any_expired_r <= 1'b0;
      rd_cnt_r      <= CNT_ZERO;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
        if (cfg_we && (cfg_ch == CH_IDX_W'(i))) begin
          reload_r[i] <= cfg_value;
        end
      end
      time_out_r    <= tout_nxt_s;
      expired_r     <= exp_nxt_s;
      busy_r        <= busy_nxt_s;
      any_expired_r <= |expired_r;
      rd_cnt_r      <= rd_sel_s;
    end
  end

  assign time_out    = time_out_r;
  assign expired     = expired_r;
  assign busy        = busy_r;
  assign any_expired = any_expired_r;
  assign rd_cnt      = rd_cnt_r;

endmodule

// File: tb/tb_time_cnt_mc.sv
// Directed bench for time_cnt_mc: a per-cycle vector table plus hand-written
// sequences for kicks, same-edge conflicts, zero reload and async reset.
module tb_time_cnt_mc;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  start, stop, periodic, clr_expired;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_value;
  logic [2:0]  rd_ch;
  logic [3:0]  time_out, expired, busy;
  logic        any_expired;
  logic [15:0] rd_cnt;

  int tests = 0;
  int fails = 0;

  // 16-bit counters; the default reload truncates to 12.
  time_cnt_mc #(
    .NUM_CH(4), .CNT_W(16), .DEFAULT_TIMEOUT(32'h0001_000C), .CH_IDX_W(3)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop),
    .periodic(periodic), .clr_expired(clr_expired), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_value(cfg_value), .rd_ch(rd_ch),
    .time_out(time_out), .expired(expired), .busy(busy),
    .any_expired(any_expired), .rd_cnt(rd_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  st, sp, per, clr;
    logic        we;
    logic [2:0]  ch;
    logic [15:0] val;
    logic [2:0]  rd;
    logic [3:0]  e_to, e_exp, e_busy;
    logic        e_any;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] per,
                     input logic [3:0] clr, input logic we, input logic [2:0] ch,
                     input logic [15:0] val, input logic [2:0] rd, input logic [3:0] e_to,
                     input logic [3:0] e_exp, input logic [3:0] e_busy, input logic e_any,
                     input logic [15:0] e_rd);
    vec_t v;
    v.st = st; v.sp = sp; v.per = per; v.clr = clr; v.we = we; v.ch = ch;
    v.val = val; v.rd = rd; v.e_to = e_to; v.e_exp = e_exp; v.e_busy = e_busy;
    v.e_any = e_any; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  logic [3:0] to_seen;

  initial begin
    areset = 1'b0; start = 4'd0; stop = 4'd0; periodic = 4'd0; clr_expired = 4'd0;
    cfg_we = 1'b0; cfg_ch = 3'd0; cfg_value = 16'd0; rd_ch = 3'd0;
    #1 areset = 1'b1;
    #1 chk("reset_state", {time_out, expired, busy, any_expired, rd_cnt}, 64'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;

    // One-shot ch0 reload 5, then periodic ch1 reload 3, stop and flag clear.
    add(4'h0,4'h0,4'h0,4'h0, 1'b1,3'd0,16'd5, 3'd0, 4'h0,4'h0,4'h0,1'b0,16'd0);
    add(4'h1,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd0, 4'h0,4'h0,4'h1,1'b0,16'd0);
    add(4'h0,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd0, 4'h0,4'h0,4'h1,1'b0,16'd5);
    add(4'h0,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd0, 4'h0,4'h0,4'h1,1'b0,16'd4);
    add(4'h0,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd0, 4'h0,4'h0,4'h1,1'b0,16'd3);
    add(4'h0,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd0, 4'h0,4'h0,4'h1,1'b0,16'd2);
    add(4'h0,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd0, 4'h1,4'h1,4'h0,1'b0,16'd1);
    add(4'h0,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd0, 4'h0,4'h1,4'h0,1'b1,16'd0);
    add(4'h0,4'h0,4'h2,4'h0, 1'b1,3'd1,16'd3, 3'd1, 4'h0,4'h1,4'h0,1'b1,16'd0);
    add(4'h2,4'h0,4'h2,4'h0, 1'b0,3'd0,16'd0, 3'd1, 4'h0,4'h1,4'h2,1'b1,16'd0);
    for (int k = 0; k < 3; k++) begin
      add(4'h0,4'h0,4'h2,4'h0, 1'b0,3'd0,16'd0, 3'd1, 4'h0,(k == 0) ? 4'h1 : 4'h3,4'h2,1'b1,16'd3);
      add(4'h0,4'h0,4'h2,4'h0, 1'b0,3'd0,16'd0, 3'd1, 4'h0,(k == 0) ? 4'h1 : 4'h3,4'h2,1'b1,16'd2);
      add(4'h0,4'h0,4'h2,4'h0, 1'b0,3'd0,16'd0, 3'd1, 4'h2,4'h3,4'h2,1'b1,16'd1);
    end
    add(4'h0,4'h2,4'h2,4'h0, 1'b0,3'd0,16'd0, 3'd1, 4'h0,4'h3,4'h0,1'b1,16'd3);
    for (int k = 0; k < 3; k++) begin
      add(4'h0,4'h0,4'h2,4'h0, 1'b0,3'd0,16'd0, 3'd1, 4'h0,4'h3,4'h0,1'b1,16'd0);
    end
    add(4'h0,4'h0,4'h0,4'h3, 1'b0,3'd0,16'd0, 3'd1, 4'h0,4'h0,4'h0,1'b1,16'd0);
    add(4'h0,4'h0,4'h0,4'h0, 1'b0,3'd0,16'd0, 3'd1, 4'h0,4'h0,4'h0,1'b0,16'd0);

    foreach (vecs[i]) begin
      start = vecs[i].st; stop = vecs[i].sp; periodic = vecs[i].per;
      clr_expired = vecs[i].clr; cfg_we = vecs[i].we; cfg_ch = vecs[i].ch;
      cfg_value = vecs[i].val; rd_ch = vecs[i].rd;
      step();
      chk($sformatf("vec%0d", i), {time_out, expired, busy, any_expired, rd_cnt},
          {vecs[i].e_to, vecs[i].e_exp, vecs[i].e_busy, vecs[i].e_any, vecs[i].e_rd});
    end
    start = 4'd0; stop = 4'd0; periodic = 4'd0; clr_expired = 4'd0; cfg_we = 1'b0;

    // Kick ch2 (reload 4) three edges after start: no pulse at +4, pulse at +7.
    cfg_we = 1'b1; cfg_ch = 3'd2; cfg_value = 16'd4; rd_ch = 3'd2; step(); cfg_we = 1'b0;
    start = 4'h4; step(); start = 4'h0;
    step(); step();
    start = 4'h4; step(); start = 4'h0;
    chk("kick_busy", busy[2], 1'b1);
    step(); chk("kick_no_pulse", time_out[2], 1'b0);
    step(); step(); chk("kick_no_pulse_late", time_out[2], 1'b0);
    step(); chk("kick_pulse", time_out[2], 1'b1);
    chk("kick_expired", expired[2], 1'b1);
    start = 4'h4; step(); start = 4'h0;
    chk("start_clears_exp", expired[2], 1'b0);
    stop = 4'h4; start = 4'h4; step(); stop = 4'h0; start = 4'h0;
    chk("stop_beats_start", busy[2], 1'b0);
    step(); chk("stop_clears_cnt", rd_cnt, 16'd0);

    // Reload write on the start edge: this run uses 5, the next one 9.
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_value = 16'd9; start = 4'h1; step();
    cfg_we = 1'b0; start = 4'h0;
    repeat (4) step(); chk("old_reload_early", time_out[0], 1'b0);
    step(); chk("old_reload_pulse", time_out[0], 1'b1);
    start = 4'h1; step(); start = 4'h0;
    chk("restart_clears_exp", expired[0], 1'b0);
    repeat (8) step(); chk("new_reload_early", time_out[0], 1'b0);
    clr_expired = 4'h1; step(); clr_expired = 4'h0;
    chk("new_reload_pulse", time_out[0], 1'b1);
    chk("set_beats_clr", expired[0], 1'b1);

    // Zero reload on ch3 behaves as one; out-of-range config is ignored.
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_value = 16'd0; step(); cfg_we = 1'b0;
    start = 4'h8; step(); start = 4'h0;
    chk("zero_busy", busy[3], 1'b1);
    chk("zero_no_early", time_out[3], 1'b0);
    step(); chk("zero_pulse", time_out[3], 1'b1);
    cfg_we = 1'b1; cfg_ch = 3'd7; cfg_value = 16'd2; step(); cfg_we = 1'b0;
    start = 4'h8; step(); start = 4'h0;
    step(); chk("bad_ch_ignored", time_out[3], 1'b1);

    // Readback: out-of-range index reads 0, ch0 reads its previous count.
    start = 4'h1; step(); start = 4'h0;
    rd_ch = 3'd5; step(); chk("rd_oob", rd_cnt, 16'd0);
    rd_ch = 3'd0; step(); chk("rd_ch0", rd_cnt, 16'd8);
    repeat (5) step();
    chk("pre_reset_busy", busy[0], 1'b1);
    chk("pre_reset_rd", rd_cnt, 16'd3);

    // Asynchronous reset with ch0 at count 2.
    #2 areset = 1'b1;
    #1 chk("async_reset", {time_out, expired, busy, any_expired, rd_cnt}, 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    to_seen = 4'h0;
    for (int k = 0; k < 12; k++) begin
      step();
      to_seen = to_seen | time_out;
    end
    chk("no_pulse_after_reset", to_seen, 4'h0);
    chk("idle_after_reset", busy, 4'h0);
    start = 4'h1; step(); start = 4'h0;
    repeat (11) step(); chk("default_reload_early", time_out[0], 1'b0);
    step(); chk("default_reload_pulse", time_out[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_cnt_mc.md
Name: time_cnt_mc

Overview:
- Multi-channel, parametrised successor of the single-shot kernel timeout counter.
- Provides NUM_CH independent countdown timers, each with:
  - a runtime-programmable reload value
  - one-shot or periodic mode
  - restart (kick), stop, a sticky expiry flag and count readback
- Sits beside kernel control logic. Each ap_start-style pulse arms a channel; a timeout pulse or flag drives watchdog/abort handling.

Parameters:
- NUM_CH, 4: number of independent timer channels (1..16).
- CNT_W, 32: counter and reload width in bits.
- DEFAULT_TIMEOUT, 32'h7735_9400: reset value of every channel's reload register (about 8 s at 250 MHz). Truncated to CNT_W.
- CH_IDX_W, 2: width of channel index ports; must satisfy 2**CH_IDX_W >= NUM_CH.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- start  in  NUM_CH  per-channel start/kick pulse; loads the reload value and runs.
- stop  in  NUM_CH  per-channel stop; returns the channel to IDLE, count cleared.
- periodic  in  NUM_CH  per-channel mode, sampled at expiry: 1 = auto-reload, 0 = one-shot.
- clr_expired  in  NUM_CH  per-channel clear of the sticky expired flag.
- cfg_we  in  1  reload register write strobe.
- cfg_ch  in  CH_IDX_W  channel addressed by cfg_we.
- cfg_value  in  CNT_W  new reload value.
- rd_ch  in  CH_IDX_W  channel selected for count readback.
- time_out  out  NUM_CH  one-cycle registered expiry pulse per channel.
- expired  out  NUM_CH  sticky expiry flag per channel.
- busy  out  NUM_CH  1 while the channel is in RUN.
- any_expired  out  1  OR-reduction of expired (registered).
- rd_cnt  out  CNT_W  current count of channel rd_ch (registered, 1-cycle latency).

Behaviour:

Reset (async, on areset=1):
- All channels IDLE; cnt=0.
- reload = DEFAULT_TIMEOUT.
- time_out, expired, busy, any_expired and rd_cnt are all 0.

Per-channel states:
- IDLE: cnt holds 0.
  - start=1 -> RUN with cnt = eff(reload).
- RUN: each cycle, cnt decrements by 1.
  - When cnt==1 at a clock edge:
    - cnt becomes 0
    - time_out pulses high for the following cycle
    - expired is set
    - if periodic=1: cnt = eff(reload) instead of 0 and the channel stays RUN
    - else -> EXPIRED
- EXPIRED: cnt holds 0; busy=0.
  - start=1 -> RUN (also clears expired).
  - stop=1 -> IDLE (expired is kept).

Timing and arithmetic:
- eff(x) = x when x != 0, otherwise 1. A reload of 0 never hangs the channel.
- Latency: start sampled at edge E with reload R -> time_out high in the cycle after edge E+R. Exactly R cycles from start to pulse.
- Periodic mode: time_out pulses every R cycles.
- The counter never wraps; decrement only occurs when cnt != 0.

Priority per channel, same edge (highest first):
1. stop: IDLE, cnt=0, no time_out, even if cnt==1.
2. start: restart (kick). Reload overrides an expiry on the same edge; no pulse; expired is cleared.
3. Countdown or expiry.
4. clr_expired: loses to an expiry setting expired on the same edge (set wins).
- start clears expired.

Configuration:
- cfg_we writes reload[cfg_ch] at the edge.
- Never alters a running count; the new value takes effect at the next load.
- start and cfg_we on the same channel at the same edge: the load uses the old reload value.
- cfg_ch >= NUM_CH: the write is ignored.

Readback:
- rd_cnt is registered with cnt[rd_ch] from the previous cycle.
- rd_ch >= NUM_CH returns 0.

Other outputs:
- busy is registered and is 1 exactly while the channel is in RUN.
- any_expired is registered: OR of the expired values after the edge, one cycle behind expired.

Channels are fully independent; simultaneous events on different channels do not interact.

Reset asserted mid-count: outputs clear immediately (async) with no time_out pulse. Counting resumes only after a new start.

Test Plan:
1. cfg_we ch0 with value 5; start[0] pulse at edge 0 with periodic=0 -> busy[0]=1; time_out[0] high one cycle after edge 5; expired[0]=1, any_expired=1 one cycle later; ch0 EXPIRED, rd_cnt=0.
2. ch1 reload 3, periodic=1, start once -> time_out[1] pulses at cycles 3, 6, 9 after start; busy stays 1. Then stop[1] -> busy=0 and no further pulses.
3. Kick: ch2 reload 4; start at edge 0 and again at edge 3 (cnt==1) -> no pulse at edge 4; pulse at edge 7.
4. Same-edge conflicts: stop and start together -> IDLE. cfg_we(ch0 with value 9) together with start[0] (old value 5) -> pulse after 5 cycles; the next start runs 9 cycles. clr_expired coinciding with expiry -> expired=1.
5. Reload 0 on ch3, start -> time_out[3] one cycle after the start edge. cfg_ch=7 with NUM_CH=4 -> no register changes.
6. areset asserted asynchronously mid-count (ch0 cnt=2) -> all outputs 0 before the next edge; reload returns to DEFAULT_TIMEOUT; no pulse after release until a new start.
